// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: arbitrates load-use, multiply, branch and halt into pipeline enables/flushes.
// Ports: clk, rst (sync, active-high); conflict_stall, branch_taken_ex, mul_ex, halt in;
//        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush, mul_busy,
//        stall_cnt, flush_cnt out.
module hazard_stall_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             conflict_stall,
    input  logic             branch_taken_ex,
    input  logic             mul_ex,
    input  logic             halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             mul_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef enum logic [1:0] {RUN, MUL_WAIT, HALT} state_t;
    localparam logic [3:0] MLOAD = (MUL_CYCLES >= 2) ? 4'(MUL_CYCLES - 2) : 4'd0;
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    state_t state_q, state_d;
    logic [3:0] mcnt_q, mcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic run, mul_go, frz, mstall, br, ld;
    always_comb begin
        run    = (state_q == RUN) && !halt;
        mul_go = run && mul_ex && (MUL_CYCLES >= 2);
        // halt wins in both RUN and MUL_WAIT; HALT itself is sticky until rst
        frz    = (state_q == HALT) || halt;
        mstall = mul_go || ((state_q == MUL_WAIT) && !halt && (mcnt_q != 4'd0));
        br     = run && !mul_go && branch_taken_ex;
        ld     = run && !mul_go && !branch_taken_ex && conflict_stall;
        pc_en       = !(frz || mstall || ld);
        ifid_en     = !(frz || mstall || ld);
        idex_en     = !(frz || mstall);
        ifid_flush  = br;
        idex_flush  = br || ld;
        exmem_flush = mstall;
        mul_busy    = (state_q == MUL_WAIT);
        state_d = frz ? HALT : mul_go ? MUL_WAIT :
                  ((state_q == MUL_WAIT) && (mcnt_q != 4'd0)) ? MUL_WAIT : RUN;
        mcnt_d  = mul_go ? MLOAD : (state_q == MUL_WAIT && !halt && mcnt_q != 4'd0) ? mcnt_q - 4'd1 : mcnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            mcnt_q      <= 4'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            mcnt_q  <= mcnt_d;
            if ((mstall || ld) && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + ONE;
            if (br && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + ONE;
        end
    end
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed checks of hazard_stall_ctrl with MUL_CYCLES 4/1 and CNT_W 4.
module tb_hazard_stall_ctrl;
    logic clk = 0, rst = 1, cs = 0, br = 0, mx = 0, hl = 0;
    logic pc0, ie0, if0, de0, df0, ef0, mb0, pc1, ie1, if1, de1, df1, ef1, mb1;
    logic pc2, ie2, if2, de2, df2, ef2, mb2;
    logic [31:0] sc0, fc0, sc1, fc1;
    logic [3:0] sc2, fc2;
    int total = 0, bad = 0;
    always #5 clk = ~clk;
    hazard_stall_ctrl #(.MUL_CYCLES(4), .CNT_W(32)) u0 (.clk(clk), .rst(rst), .conflict_stall(cs),
        .branch_taken_ex(br), .mul_ex(mx), .halt(hl), .pc_en(pc0), .ifid_en(ie0), .ifid_flush(if0),
        .idex_en(de0), .idex_flush(df0), .exmem_flush(ef0), .mul_busy(mb0), .stall_cnt(sc0), .flush_cnt(fc0));
    hazard_stall_ctrl #(.MUL_CYCLES(1), .CNT_W(32)) u1 (.clk(clk), .rst(rst), .conflict_stall(cs),
        .branch_taken_ex(br), .mul_ex(mx), .halt(hl), .pc_en(pc1), .ifid_en(ie1), .ifid_flush(if1),
        .idex_en(de1), .idex_flush(df1), .exmem_flush(ef1), .mul_busy(mb1), .stall_cnt(sc1), .flush_cnt(fc1));
    hazard_stall_ctrl #(.MUL_CYCLES(4), .CNT_W(4)) u2 (.clk(clk), .rst(rst), .conflict_stall(cs),
        .branch_taken_ex(br), .mul_ex(mx), .halt(hl), .pc_en(pc2), .ifid_en(ie2), .ifid_flush(if2),
        .idex_en(de2), .idex_flush(df2), .exmem_flush(ef2), .mul_busy(mb2), .stall_cnt(sc2), .flush_cnt(fc2));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        {cs, br, mx, hl} = 4'b0;
        rst = 1;
        cyc();
        rst = 0;
    endtask
    initial begin
        cyc();
        do_reset();
        #1;
        chk("rst_pc", pc0, 1);
        chk("rst_en", {ie0, de0}, 2'b11);
        chk("rst_fl", {if0, df0, ef0}, 0);
        chk("rst_busy", mb0, 0);
        chk("rst_cnt", {sc0, fc0}, 0);
        mx = 1;
        #1;
        chk("mr_pc", pc0, 0);
        chk("mr_ef", ef0, 1);
        cyc();
        mx = 0;
        rst = 1;
        #1;
        chk("mr_busy", mb0, 1);
        cyc();
        rst = 0;
        #1;
        chk("mr_busy0", mb0, 0);
        chk("mr_sc", sc0, 0);
        chk("mr_en", {pc0, ie0, de0}, 3'b111);
        cs = 1;
        #1;
        chk("ld_en", {pc0, ie0, de0}, 3'b001);
        chk("ld_fl", {if0, df0, ef0}, 3'b010);
        cyc();
        cs = 0;
        #1;
        chk("ld_after", {pc0, ie0, df0}, 3'b110);
        chk("ld_sc", sc0, 1);
        do_reset();
        cs = 1;
        br = 1;
        #1;
        chk("br_fl", {if0, df0, ef0}, 3'b110);
        chk("br_en", {pc0, ie0, de0}, 3'b111);
        cyc();
        {cs, br} = 2'b0;
        #1;
        chk("br_fc", fc0, 1);
        chk("br_sc", sc0, 0);
        do_reset();
        mx = 1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk($sformatf("m4_pc%0d", i), pc0, (i < 4) ? 1'b0 : 1'b1);
            chk($sformatf("m4_busy%0d", i), mb0, (i > 1) ? 1'b1 : 1'b0);
            chk($sformatf("m4_ef%0d", i), ef0, (i < 4) ? 1'b1 : 1'b0);
            chk($sformatf("m1_%0d", i), {pc1, ie1, de1, ef1, mb1}, 5'b11100);
            cyc();
        end
        mx = 0;
        #1;
        chk("m4_sc", sc0, 3);
        chk("m4_rel", {pc0, mb0}, 2'b10);
        chk("m1_sc", sc1, 0);
        do_reset();
        mx = 1;
        cyc();
        mx = 0;
        hl = 1;
        #1;
        chk("h_prio", {pc0, ie0, de0, if0, df0, ef0}, 0);
        cyc();
        hl = 0;
        for (int i = 0; i < 10; i++) begin
            cs = i[0];
            br = i[1];
            mx = i[2];
            #1;
            chk($sformatf("h_en%0d", i), {pc0, ie0, de0}, 0);
            chk($sformatf("h_fl%0d", i), {if0, df0, ef0, mb0}, 0);
            cyc();
        end
        chk("h_sc", sc0, 1);
        chk("h_fc", fc0, 0);
        do_reset();
        #1;
        chk("h_exit", {pc0, ie0, de0, mb0}, 4'b1110);
        do_reset();
        cs = 1;
        for (int i = 0; i < 20; i++) cyc();
        cs = 0;
        #1;
        chk("sat_sc", sc2, 15);
        chk("wide_sc", sc0, 20);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline control block that consumes the load-use bubble request from hazard detection and arbitrates it against branch redirects, multi-cycle multiply occupancy and halt. It drives per-stage enable and flush signals for PC, IF/ID, ID/EX and EX/MEM, and keeps saturating stall and flush statistics counters. It sits between the hazard detector, the EX-stage branch and multiply logic, and the pipeline registers.

Parameters:
MUL_CYCLES, 4, total cycles a multiply occupies EX. Legal range 1..16; 1 means a single-cycle multiply with no stall.
CNT_W, 32, width of the statistics counters.

Ports:
clk  input  1  clock, all state updates on the rising edge
rst  input  1  synchronous reset, active-high
conflict_stall  input  1  load-use bubble request from hazard detection
branch_taken_ex  input  1  taken branch or jump resolved in EX; PC loads the target this cycle
mul_ex  input  1  multiply instruction present in EX
halt  input  1  halt or syscall retiring; freezes the pipeline until rst
pc_en  output  1  PC register write enable
ifid_en  output  1  IF/ID register write enable
ifid_flush  output  1  IF/ID loads NOP
idex_en  output  1  ID/EX register write enable
idex_flush  output  1  ID/EX loads NOP (bubble)
exmem_flush  output  1  EX/MEM loads NOP
mul_busy  output  1  high while state is MUL_WAIT
stall_cnt  output  CNT_W  count of load-use and multiply stall cycles
flush_cnt  output  CNT_W  count of branch flush cycles

Behaviour:
- States: RUN, MUL_WAIT, HALT. Internal down-counter mcnt, 4 bits.
- Reset: state=RUN, mcnt=0, stall_cnt=0, flush_cnt=0. rst has priority over all inputs, including in the middle of a multiply or in HALT.
- Control outputs are combinational from state and inputs. Default, with no event: pc_en=ifid_en=idex_en=1 and all flushes=0.
- Priority in RUN: halt > mul_ex > branch_taken_ex > conflict_stall.
- RUN with halt: go to HALT. This cycle all enables=0 and all flushes=0.
- RUN with mul_ex and MUL_CYCLES>=2:
  - Stall pattern this cycle: pc_en=ifid_en=idex_en=0, exmem_flush=1.
  - mcnt<=MUL_CYCLES-2, go to MUL_WAIT, stall_cnt+1.
- RUN with mul_ex and MUL_CYCLES=1: mul_ex is ignored.
- RUN with branch_taken_ex: ifid_flush=1, idex_flush=1, all enables=1, flush_cnt+1. branch_taken_ex overrides a concurrent conflict_stall because the stalled instruction is squashed.
- RUN with conflict_stall only: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, stall_cnt+1.
- MUL_WAIT:
  - halt has priority: go to HALT.
  - If mcnt!=0: stall pattern as above, mcnt-1, stall_cnt+1.
  - If mcnt==0: release cycle with default outputs; go to RUN.
  - mul_ex, branch_taken_ex and conflict_stall are ignored in this state. mul_ex is still high in the release cycle and must not retrigger.
- Multiply occupancy: EX holds the multiply for exactly MUL_CYCLES cycles and pc_en is low for MUL_CYCLES-1 cycles. A back-to-back multiply arriving in EX the cycle after release restarts the sequence from RUN.
- HALT: all enables=0 and all flushes=0 every cycle. Counters hold. Only rst exits this state.
- Counters: increment at most 1 per cycle and saturate at all-ones; they do not wrap.
- mul_busy = (state==MUL_WAIT).

Test Plan:
- Reset in the middle of MUL_WAIT (MUL_CYCLES=4, rst asserted the cycle after mul_ex) -> next cycle state=RUN, mul_busy=0, stall_cnt=0, default enables.
- conflict_stall=1 for one cycle in RUN -> pc_en=0, ifid_en=0, idex_flush=1 for that cycle only; stall_cnt=1.
- conflict_stall=1 and branch_taken_ex=1 together -> ifid_flush=1, idex_flush=1, pc_en=1; flush_cnt=1, stall_cnt=0.
- MUL_CYCLES=4, mul_ex held high for 4 cycles -> pc_en low for cycles 1-3 and high in cycle 4; mul_busy high in cycles 2-4; exmem_flush=1 in cycles 1-3; stall_cnt=3. Repeating with MUL_CYCLES=1 -> no stall at all.
- halt asserted in MUL_WAIT -> HALT from the next cycle; all enables stay 0 for 10 cycles regardless of inputs; rst restores RUN.
- CNT_W=4, 20 conflict_stall cycles -> stall_cnt saturates at 15 and does not wrap.
